// File: rtl/rrf_alloc_if.sv
// Dispatch/commit/recovery signal bundle for the rename-register allocator.
// The core (master) drives requests and commit/flush info; the allocator (slave) returns grants.
interface rrf_alloc_if #(
  parameter int RRF_SEL = 6
);
  logic               req1;
  logic               req2;
  logic               stall_in;
  logic [1:0]         comnum;
  logic [RRF_SEL-1:0] comptr;
  logic               prmiss;
  logic [RRF_SEL-1:0] rollback_ptr;
  logic               dp1;
  logic               dp2;
  logic [RRF_SEL-1:0] dp1_addr;
  logic [RRF_SEL-1:0] dp2_addr;
  logic [RRF_SEL-1:0] dispatchptr;
  logic [RRF_SEL:0]   rrf_freenum;
  logic               recovering;
  logic               err;

  modport master (
    output req1, req2, stall_in, comnum, comptr, prmiss, rollback_ptr,
    input  dp1, dp2, dp1_addr, dp2_addr, dispatchptr, rrf_freenum, recovering, err
  );

  modport slave (
    input  req1, req2, stall_in, comnum, comptr, prmiss, rollback_ptr,
    output dp1, dp2, dp1_addr, dp2_addr, dispatchptr, rrf_freenum, recovering, err
  );
endinterface

// File: rtl/rrf_alloc_ctrl.sv
// Rename/reorder-buffer entry allocator: up to two in-order grants per cycle,
// commit-driven free accounting, and misprediction rollback with a short grant blackout.
module rrf_alloc_ctrl #(
  parameter int RRF_NUM     = 64,
  parameter int RRF_SEL     = 6,
  parameter int RECOVER_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  rrf_alloc_if.slave       bus
);

  typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [RRF_SEL:0]   NUM_W   = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL+1:0] NUM_X   = (RRF_SEL+2)'(RRF_NUM);
  localparam logic [3:0]         LAT_W   = 4'(RECOVER_LAT);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [RRF_SEL-1:0] r_dispatchptr;
  logic [RRF_SEL:0]   r_freenum;
  logic               r_err;

  logic               w_dp1;
  logic               w_dp2;
  logic [1:0]         w_comnum;
  logic [RRF_SEL+1:0] w_sum;
  logic               w_ovf;
  logic [RRF_SEL:0]   w_sat;
  logic [RRF_SEL:0]   w_free_nxt;
  logic [RRF_SEL-1:0] w_ptr_nxt;
  logic [RRF_SEL-1:0] w_rb_occ;
  logic [RRF_SEL:0]   w_rb_free;
  logic               w_req_err;
  logic               w_com_err;

  // Grants look only at the registered free count, so same-cycle commits help next cycle.
  assign w_dp1 = ~reset & bus.req1 & ~bus.stall_in & ~bus.prmiss &
                 (r_state == NORMAL) & (r_freenum >= (RRF_SEL+1)'(1));
  assign w_dp2 = w_dp1 & bus.req2 & (r_freenum >= (RRF_SEL+1)'(2));

  assign w_req_err = bus.req2 & ~bus.req1;
  assign w_com_err = (bus.comnum == 2'd3);
  assign w_comnum  = w_com_err ? 2'd2 : bus.comnum;

  assign w_sum      = {1'b0, r_freenum} + (RRF_SEL+2)'(w_comnum);
  assign w_ovf      = (w_sum > NUM_X);
  assign w_sat      = w_ovf ? NUM_W : w_sum[RRF_SEL:0];
  assign w_free_nxt = w_sat - (RRF_SEL+1)'(w_dp1) - (RRF_SEL+1)'(w_dp2);
  assign w_ptr_nxt  = r_dispatchptr + RRF_SEL'(w_dp1) + RRF_SEL'(w_dp2);

  // Rollback: everything from comptr up to (not including) rollback_ptr stays live;
  // equal pointers mean the buffer is completely full.
  assign w_rb_occ  = bus.rollback_ptr - bus.comptr;
  assign w_rb_free = (w_rb_occ == '0) ? '0 : (NUM_W - (RRF_SEL+1)'(w_rb_occ));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= NORMAL;
      r_cnt         <= 4'd0;
      r_dispatchptr <= '0;
      r_freenum     <= NUM_W;
      r_err         <= 1'b0;
    end else begin
      r_err <= r_err | w_req_err | w_com_err | (~bus.prmiss & w_ovf);
      if (bus.prmiss) begin
        r_state       <= RECOVER;
        r_cnt         <= LAT_W;
        r_dispatchptr <= bus.rollback_ptr;
        r_freenum     <= w_rb_free;
      end else begin
        r_dispatchptr <= w_ptr_nxt;
        r_freenum     <= w_free_nxt;
        if (r_state == RECOVER) begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= NORMAL;
        end
      end
    end
  end

  assign bus.dp1         = w_dp1;
  assign bus.dp2         = w_dp2;
  assign bus.dp1_addr    = r_dispatchptr;
  assign bus.dp2_addr    = r_dispatchptr + RRF_SEL'(1);
  assign bus.dispatchptr = r_dispatchptr;
  assign bus.rrf_freenum = r_freenum;
  assign bus.recovering  = (r_state == RECOVER);
  assign bus.err         = r_err;

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Directed bench for rrf_alloc_ctrl: each step pushes its expected outputs to a
// scoreboard queue, then pops and compares them mid-cycle.
module tb_rrf_alloc_ctrl;
  localparam int N   = 64;
  localparam int SEL = 6;

  typedef struct {
    int dp1, dp2, a1, a2, ptr, free, rec, err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  rrf_alloc_if #(.RRF_SEL(SEL)) bus ();

  rrf_alloc_ctrl #(.RRF_NUM(N), .RRF_SEL(SEL), .RECOVER_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string tag, logic [31:0] obs, int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endfunction

  task automatic drive(input logic r1, r2, st, input logic [1:0] cn,
                       input int cp, pm, rb);
    bus.req1 = r1; bus.req2 = r2; bus.stall_in = st; bus.comnum = cn;
    bus.comptr = SEL'(cp); bus.prmiss = pm[0]; bus.rollback_ptr = SEL'(rb);
  endtask

  // One cycle: drive, enqueue expectation, compare at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic r1, r2, st, input logic [1:0] cn,
                     input int cp, pm, rb,
                     input int dp1, dp2, ptr, free, rec, err);
    exp_t e, o;
    drive(r1, r2, st, cn, cp, pm, rb);
    e.dp1 = dp1; e.dp2 = dp2; e.a1 = ptr; e.a2 = (ptr + 1) % N;
    e.ptr = ptr; e.free = free; e.rec = rec; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk({tag, ".dp1"},  32'(bus.dp1),         o.dp1);
    chk({tag, ".dp2"},  32'(bus.dp2),         o.dp2);
    chk({tag, ".a1"},   32'(bus.dp1_addr),    o.a1);
    chk({tag, ".a2"},   32'(bus.dp2_addr),    o.a2);
    chk({tag, ".ptr"},  32'(bus.dispatchptr), o.ptr);
    chk({tag, ".free"}, 32'(bus.rrf_freenum), o.free);
    chk({tag, ".rec"},  32'(bus.recovering),  o.rec);
    chk({tag, ".err"},  32'(bus.err),         o.err);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1, 1, 0, 2'd2, 3, 1, 9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.dp1",  32'(bus.dp1), 0);
    chk("rst.dp2",  32'(bus.dp2), 0);
    chk("rst.ptr",  32'(bus.dispatchptr), 0);
    chk("rst.free", 32'(bus.rrf_freenum), N);
    chk("rst.rec",  32'(bus.recovering), 0);
    chk("rst.err",  32'(bus.err), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    drive(0, 0, 0, 2'd0, 0, 0, 0);
    do_reset();

    // Fill: 32 dual grants walk the pointer 0..62 and drain the free count.
    for (int i = 0; i < 32; i++)
      cyc("fill", 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, (2 * i) % N, N - 2 * i, 0, 0);
    cyc("full", 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Commits free entries but they are grantable only the next cycle.
    cyc("samefree", 1, 1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("afterfree", 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0, 2, 0, 0);

    // Partial grant with a single free entry.
    cyc("free1", 0, 0, 0, 2'd1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc("partial", 1, 1, 0, 2'd0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
    cyc("partial2", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

    // Rollback to 63 (two live entries), recovery blackout, then wrapping dual grant.
    cyc("pm63", 1, 0, 0, 2'd2, 61, 1, 63, 0, 0, 3, 0, 0, 0);
    cyc("rec63", 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 63, 62, 1, 0);
    cyc("wrap", 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, 63, 62, 0, 0);
    cyc("wrap2", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 60, 0, 0);

    // Rollback comptr=10 -> 15; commits still counted while recovering.
    cyc("pm15", 1, 0, 0, 2'd0, 10, 1, 15, 0, 0, 1, 60, 0, 0);
    cyc("rec15", 1, 0, 0, 2'd1, 0, 0, 0, 0, 0, 15, 59, 1, 0);
    cyc("grant15", 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 15, 60, 0, 0);
    cyc("stall", 1, 1, 1, 2'd0, 0, 0, 0, 0, 0, 16, 59, 0, 0);

    // Equal pointers mean full; a second prmiss during recovery reapplies rollback.
    cyc("pmeq", 0, 0, 0, 2'd0, 20, 1, 20, 0, 0, 16, 59, 0, 0);
    cyc("pmagain", 1, 1, 0, 2'd0, 5, 1, 6, 0, 0, 20, 0, 1, 0);
    cyc("ovf", 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 6, 63, 1, 0);
    cyc("sat", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 6, 64, 0, 1);

    // req2 without req1: no grant, sticky error.
    do_reset();
    cyc("req2only", 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64, 0, 0);
    cyc("errhold", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64, 0, 1);
    cyc("errhold2", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 64, 0, 1);

    // comnum==3 counts as 2 and flags an error.
    do_reset();
    cyc("g0", 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0, 64, 0, 0);
    cyc("g1", 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, 2, 62, 0, 0);
    cyc("com3", 0, 0, 0, 2'd3, 0, 0, 0, 0, 0, 4, 60, 0, 0);
    cyc("com3b", 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 4, 62, 0, 1);

    chk("sb.empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
